// File: rtl/csi_raw_unpack.sv
// -----------------------------------------------------------------------------
// csi_raw_unpack
//
// Converts CSI-2 RAW payload bytes from the lane aligner into beats of four
// pixels for the ISP. The RAW format (RAW8/10/12/14) is chosen per line. The
// block latches it while idle, so a mode change in the middle of a line only
// takes effect on the next line.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   mode            : 0=RAW8 1=RAW10 2=RAW12 3=RAW14 (sampled only while idle)
//   in_vld          : all NUM_LANE bytes of in_data are valid
//   in_data         : payload bytes, lane 0 ([7:0]) is the earliest
//   in_line_end     : one-cycle pulse marking the end of a line's payload
//   err_clr         : clears err_align (a simultaneous set wins)
//   pix_vld         : pix_data holds four valid pixels
//   pix_data        : pixel 0 (earliest) in [PIX_W-1:0], right-aligned
//   pix_line_end    : one-cycle pulse after the last beat of a line
//   err_align       : sticky; line had residual bytes, or data came in FLUSH
// -----------------------------------------------------------------------------
module csi_raw_unpack #(
  parameter int NUM_LANE  = 2,
  parameter int PIX_W     = 14,
  parameter int BUF_BYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic                  in_vld,
  input  logic [NUM_LANE*8-1:0] in_data,
  input  logic                  in_line_end,
  input  logic                  err_clr,
  output logic                  pix_vld,
  output logic [4*PIX_W-1:0]    pix_data,
  output logic                  pix_line_end,
  output logic                  err_align
);

  localparam int CW = $clog2(BUF_BYTES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_FLUSH, S_END} state_t;
  typedef enum logic [1:0] {RAW8, RAW10, RAW12, RAW14} raw_t;

  state_t               state_q, state_d;
  raw_t                 mode_q, mode_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           buf_q [BUF_BYTES];
  logic [7:0]           buf_d [BUF_BYTES];
  logic                 pix_vld_q, pix_vld_d;
  logic [4*PIX_W-1:0]   pix_data_q, pix_data_d;
  logic                 pix_line_end_q, pix_line_end_d;
  logic                 err_q, err_d;

  logic [CW-1:0]        grp;      // bytes consumed per output beat
  logic                 fire;
  logic                 accept;
  logic                 err_set;
  logic [CW-1:0]        base;     // write position after this cycle's pop
  logic [13:0]          pix [4];

  // The four modes map to group sizes 4..7, one more byte per step.
  assign grp    = CW'(4) + CW'(mode_q);
  assign fire   = ((state_q == S_LINE) || (state_q == S_FLUSH)) && (cnt_q >= grp);
  assign accept = in_vld && ((state_q == S_IDLE) || (state_q == S_LINE));
  assign base   = cnt_q - (fire ? grp : '0);

  // ---------------------------------------------------------------------------
  // Line state machine: next state, mode latch, error set
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d        = state_q;
    mode_d         = mode_q;
    err_set        = 1'b0;
    pix_line_end_d = 1'b0;
    cnt_d          = base + (accept ? CW'(NUM_LANE) : '0);
    unique case (state_q)
      S_IDLE: begin
        mode_d = raw_t'(mode);
        if (in_vld && in_line_end)  state_d = S_FLUSH;
        else if (in_vld)            state_d = S_LINE;
        else if (in_line_end)       state_d = S_END;
      end
      S_LINE: begin
        if (in_line_end) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (in_vld)       err_set = 1'b1;
        if (cnt_q < grp)  state_d = S_END;
      end
      S_END: begin
        pix_line_end_d = 1'b1;
        if (cnt_q != '0) err_set = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // ---------------------------------------------------------------------------
  // Byte accumulator: pop one group from the head when firing, then append the
  // incoming lanes right behind whatever remains.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int j = 0; j < BUF_BYTES; j++) begin
      buf_d[j] = buf_q[j];
      if (fire) begin
        buf_d[j] = '0;
        for (int s = 4; s <= 7; s++) begin
          if ((int'(grp) == s) && (j + s < BUF_BYTES))
            buf_d[j] = buf_q[(j + s < BUF_BYTES) ? j + s : 0];
        end
      end
      for (int l = 0; l < NUM_LANE; l++) begin
        if (accept && (j == int'(base) + l)) buf_d[j] = in_data[8*l +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel extraction from the head of the accumulator
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 4; i++) pix[i] = '0;
    unique case (mode_q)
      RAW8: begin
        for (int i = 0; i < 4; i++) pix[i] = {6'd0, buf_q[i]};
      end
      RAW10: begin
        for (int i = 0; i < 4; i++) pix[i] = {4'd0, buf_q[i], buf_q[4][2*i +: 2]};
      end
      RAW12: begin
        pix[0] = {2'd0, buf_q[0], buf_q[2][3:0]};
        pix[1] = {2'd0, buf_q[1], buf_q[2][7:4]};
        pix[2] = {2'd0, buf_q[3], buf_q[5][3:0]};
        pix[3] = {2'd0, buf_q[4], buf_q[5][7:4]};
      end
      RAW14: begin
        pix[0] = {buf_q[0], buf_q[4][5:0]};
        pix[1] = {buf_q[1], buf_q[5][3:0], buf_q[4][7:6]};
        pix[2] = {buf_q[2], buf_q[6][1:0], buf_q[5][7:4]};
        pix[3] = {buf_q[3], buf_q[6][7:2]};
      end
      default: ;
    endcase
    pix_vld_d  = fire;
    pix_data_d = pix_data_q;
    if (fire) begin
      for (int i = 0; i < 4; i++) pix_data_d[i*PIX_W +: PIX_W] = PIX_W'(pix[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      mode_q         <= RAW8;
      cnt_q          <= '0;
      pix_vld_q      <= 1'b0;
      pix_data_q     <= '0;
      pix_line_end_q <= 1'b0;
      err_q          <= 1'b0;
      // NOTE: the byte buffer is reset as well. It is small, and a mid-line
      // reset must leave no stale payload behind.
      for (int j = 0; j < BUF_BYTES; j++) buf_q[j] <= '0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      cnt_q          <= cnt_d;
      pix_vld_q      <= pix_vld_d;
      pix_data_q     <= pix_data_d;
      pix_line_end_q <= pix_line_end_d;
      err_q          <= err_d;
      for (int j = 0; j < BUF_BYTES; j++) buf_q[j] <= buf_d[j];
    end
  end

  assign pix_vld      = pix_vld_q;
  assign pix_data     = pix_data_q;
  assign pix_line_end = pix_line_end_q;
  assign err_align    = err_q;

endmodule
